// File: rtl/field_serializer_pkg.sv
// Shared types for the object-buffer / serializer pair: table and buffer records,
// protobuf wire types and varint length limits.
package field_serializer_pkg;

  typedef struct packed {
    logic [28:0] field_id;
    logic [2:0]  field_type;
    logic        nested;
    logic [63:0] offset;
  } TABLE_ENTRY;

  typedef struct packed {
    logic [63:0] cpp_addr;
    logic [15:0] table_idx;
    logic [15:0] entry_count;
  } BUFFER_ENTRY;

  typedef enum logic [2:0] {
    VARINT  = 3'd0,
    FIXED64 = 3'd1,
    LEN     = 3'd2,
    FIXED32 = 3'd5
  } WIRE_TYPE;

  localparam int MAX_VARINT_BYTES = 10;
  localparam int MAX_TAG_BYTES    = 5;

endpackage

// File: rtl/field_serializer_varint_encoder.sv
// Loadable 64-bit varint encoder: presents one 7-bit group per byte, LSB group first,
// with a valid/ready byte handshake and a flag marking the final byte.
module varint_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] value_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [63:0] rem_q, rem_d;
  logic        busy_q, busy_d;

  always_comb begin
    last_o  = (rem_q[63:7] == 57'd0);
    byte_o  = {~last_o, rem_q[6:0]};
    valid_o = busy_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    if (load_i) begin
      rem_d  = value_i;
      busy_d = 1'b1;
    end else if (busy_q && ready_i) begin
      if (last_o) busy_d = 1'b0;
      else        rem_d  = rem_q >> 7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/field_serializer.sv
// Serializes one table entry into protobuf wire-format bytes: tag varint, then the
// field value fetched from memory as varint, fixed64 or fixed32.
module field_serializer
  import field_serializer_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  TABLE_ENTRY        in_entry,
  input  logic              in_entry_valid,
  input  logic [ADDR_W-1:0] cpp_base_addr,
  output logic              ser_ready,
  output logic              ser_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_byte,
  output logic              out_byte_valid,
  input  logic              out_byte_ready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TAG, ST_FETCH, ST_WAIT, ST_VALUE, ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic              nested_q, nested_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              enc_load, enc_ready, enc_valid, enc_last;
  logic [63:0]       enc_value;
  logic [7:0]        enc_byte;

  // Anything other than the two fixed encodings is serialized as a varint.
  function automatic logic is_varint(input logic [2:0] t);
    return !((t == FIXED64) || (t == FIXED32));
  endfunction

  function automatic logic [2:0] wire_type(input logic nst, input logic [2:0] t);
    if (nst)          return LEN;
    if (is_varint(t)) return VARINT;
    return t;
  endfunction

  varint_encoder u_enc (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (enc_load),
    .value_i (enc_value),
    .ready_i (enc_ready),
    .byte_o  (enc_byte),
    .valid_o (enc_valid),
    .last_o  (enc_last)
  );

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    nested_d       = nested_q;
    addr_d         = addr_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    enc_load       = 1'b0;
    enc_value      = '0;
    enc_ready      = 1'b0;
    ser_ready      = 1'b0;
    ser_done       = 1'b0;
    mem_req        = 1'b0;
    out_byte_valid = 1'b0;
    out_byte       = 8'h00;

    case (state_q)
      ST_IDLE: begin
        ser_ready = 1'b1;
        if (in_entry_valid) begin
          type_d   = in_entry.field_type;
          nested_d = in_entry.nested;
          addr_d   = cpp_base_addr + ADDR_W'(in_entry.offset);
          if (in_entry.field_id == 29'd0) begin
            state_d = ST_DONE;
          end else begin
            enc_load  = 1'b1;
            enc_value = 64'({in_entry.field_id, wire_type(in_entry.nested, in_entry.field_type)});
            state_d   = ST_TAG;
          end
        end
      end

      ST_TAG: begin
        out_byte_valid = enc_valid;
        out_byte       = enc_byte;
        enc_ready      = out_byte_ready;
        if (enc_valid && out_byte_ready && enc_last)
          state_d = nested_q ? ST_DONE : ST_FETCH;
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          if (is_varint(type_q)) begin
            enc_load  = 1'b1;
            enc_value = 64'(mem_rdata);
          end else begin
            shift_d = 64'(mem_rdata);
            cnt_d   = (type_q == FIXED64) ? 3'd7 : 3'd3;
          end
          state_d = ST_VALUE;
        end
      end

      ST_VALUE: begin
        if (is_varint(type_q)) begin
          out_byte_valid = enc_valid;
          out_byte       = enc_byte;
          enc_ready      = out_byte_ready;
          if (enc_valid && out_byte_ready && enc_last) state_d = ST_DONE;
        end else begin
          // cnt_q counts the bytes still to follow the one currently presented.
          out_byte_valid = 1'b1;
          out_byte       = shift_q[7:0];
          if (out_byte_ready) begin
            if (cnt_q == 3'd0) begin
              state_d = ST_DONE;
            end else begin
              shift_d = shift_q >> 8;
              cnt_d   = cnt_q - 3'd1;
            end
          end
        end
      end

      ST_DONE: begin
        ser_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      type_q   <= 3'd0;
      nested_q <= 1'b0;
      addr_q   <= '0;
      shift_q  <= '0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      nested_q <= nested_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
// Directed bench for field_serializer: drives table entries, models the memory port
// and the byte sink, and compares emitted bytes and handshake timing with hand-computed values.
module tb_field_serializer;
  import field_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  TABLE_ENTRY  in_entry;
  logic        in_entry_valid;
  logic [63:0] cpp_base_addr;
  logic        ser_ready, ser_done, mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic [7:0]  out_byte;
  logic        out_byte_valid, out_byte_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0]  got_q[$];
  int          done_cnt, stall_viol, oob_viol, first_valid_n, last_xfer_n, done_n;
  bit          req_seen, idle_after;
  logic [63:0] addr_seen;

  field_serializer #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_entry       (in_entry),
    .in_entry_valid (in_entry_valid),
    .cpp_base_addr  (cpp_base_addr),
    .ser_ready      (ser_ready),
    .ser_done       (ser_done),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid),
    .out_byte_ready (out_byte_ready)
  );

  always #5 clk = ~clk;

  // Drives one entry, answers the memory port after the given delays and collects bytes.
  task automatic run_entry(input logic [28:0] fid, input logic [2:0] ftype, input logic nst,
                           input logic [63:0] base, input logic [63:0] off, input logic [63:0] rdata,
                           input int gnt_dly, input int rv_dly, input bit toggle_rdy);
    int gcnt = 0, rcnt = 0;
    bit pending = 0, prev_stall = 0, done_seen = 0;
    logic [7:0] prev_byte = 8'h00;
    got_q.delete();
    done_cnt = 0; stall_viol = 0; oob_viol = 0; req_seen = 0; idle_after = 0;
    first_valid_n = -1; last_xfer_n = -1; done_n = -1; addr_seen = '0;
    @(negedge clk);
    in_entry.field_id = fid; in_entry.field_type = ftype;
    in_entry.nested = nst;   in_entry.offset = off;
    cpp_base_addr = base; in_entry_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (done_seen) begin idle_after = ser_ready; break; end
      if (ser_done) begin
        done_cnt++; done_n = n; done_seen = 1; in_entry_valid = 1'b0;
        if (out_byte_valid) oob_viol++;
      end
      if (prev_stall && (!out_byte_valid || out_byte !== prev_byte)) stall_viol++;
      out_byte_ready = toggle_rdy ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      if (out_byte_valid && first_valid_n < 0) first_valid_n = n;
      if (out_byte_valid && out_byte_ready) begin got_q.push_back(out_byte); last_xfer_n = n; end
      prev_stall = out_byte_valid && !out_byte_ready;
      prev_byte  = out_byte;
      mem_rvalid = 1'b0;
      if (pending) begin
        if (rcnt >= rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; pending = 0; end
        else rcnt++;
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        req_seen = 1; addr_seen = mem_addr;
        if (out_byte_valid) oob_viol++;
        if (gcnt >= gnt_dly) begin mem_gnt = 1'b1; pending = 1; rcnt = 0; gcnt = 0; end
        else gcnt++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; in_entry_valid = 1'b0; out_byte_ready = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({ser_ready, ser_done, mem_req, out_byte_valid} !== 4'b1000 || mem_addr !== 64'd0 || out_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got rdy/done/req/vld=%b addr=%h byte=%h exp 1000 0 00",
               {ser_ready, ser_done, mem_req, out_byte_valid}, mem_addr, out_byte);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ser_ready !== 1'b1 || out_byte_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_release got rdy=%b vld=%b exp rdy=1 vld=0", ser_ready, out_byte_valid);
    end
  endtask

  task automatic test_varint_basic;
    logic [7:0] exp[$];
    exp = '{8'h08, 8'h96, 8'h01};
    run_entry(29'd1, 3'd0, 1'b0, 64'h100, 64'h8, 64'd150, 0, 0, 1'b0);
    checks++;
    if (addr_seen !== 64'h108) begin errors++; $display("FAIL varint_addr got=%h exp=108", addr_seen); end
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL varint_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL varint_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (first_valid_n != 1) begin errors++; $display("FAIL varint_first_latency got=%0d exp=1", first_valid_n); end
    checks++;
    if (done_cnt != 1 || done_n != last_xfer_n + 1 || !idle_after) begin
      errors++; $display("FAIL varint_done got cnt=%0d at=%0d last=%0d idle=%0b exp 1 at last+1 idle=1",
                         done_cnt, done_n, last_xfer_n, idle_after);
    end
    checks++;
    if (oob_viol != 0) begin errors++; $display("FAIL varint_valid_outside got=%0d exp=0", oob_viol); end
  endtask

  task automatic test_fixed32;
    logic [7:0] exp[$];
    exp = '{8'h15, 8'h78, 8'h56, 8'h34, 8'h12};
    run_entry(29'd2, 3'd5, 1'b0, 64'h2000, 64'h10, 64'hFFFF_FFFF_1234_5678, 1, 2, 1'b0);
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL fixed32_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL fixed32_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (done_cnt != 1 || done_n != last_xfer_n + 1) begin
      errors++; $display("FAIL fixed32_done got cnt=%0d at=%0d exp 1 at %0d", done_cnt, done_n, last_xfer_n + 1);
    end
  endtask

  task automatic test_nested_and_end;
    run_entry(29'd3, 3'd0, 1'b1, 64'h0, 64'h0, 64'h0, 0, 0, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h1A) begin
      errors++; $display("FAIL nested_tag got n=%0d b0=%h exp n=1 b0=1a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++;
    if (req_seen || done_cnt != 1) begin errors++; $display("FAIL nested_mem got req=%0b done=%0d exp req=0 done=1", req_seen, done_cnt); end
    run_entry(29'd0, 3'd0, 1'b0, 64'h0, 64'h0, 64'h0, 0, 0, 1'b0);
    checks++;
    if (got_q.size() != 0 || req_seen || done_cnt != 1 || done_n != 1 || !idle_after) begin
      errors++; $display("FAIL end_marker got n=%0d req=%0b done=%0d at=%0d idle=%0b exp 0 0 1 at 1 idle=1",
                         got_q.size(), req_seen, done_cnt, done_n, idle_after);
    end
  endtask

  task automatic test_varint_stall;
    logic [7:0] exp[$];
    exp = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_entry(29'd1, 3'd0, 1'b0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b1);
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
    checks++;
    if (done_cnt != 1 || done_n != last_xfer_n + 1) begin
      errors++; $display("FAIL stall_done got cnt=%0d at=%0d exp 1 at %0d", done_cnt, done_n, last_xfer_n + 1);
    end
  endtask

  task automatic test_fixed64;
    logic [7:0] exp[$];
    exp = '{8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_entry(29'd16, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 0, 1, 1'b1);
    checks++;
    if (addr_seen !== 64'h10) begin errors++; $display("FAIL fixed64_addr_wrap got=%h exp=10", addr_seen); end
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL fixed64_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL fixed64_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL fixed64_stable got=%0d exp=0", stall_viol); end
  endtask

  task automatic test_illegal_and_zero;
    logic [7:0] exp[$];
    exp = '{8'h28, 8'hAC, 8'h02};
    run_entry(29'd5, 3'd3, 1'b0, 64'h0, 64'h0, 64'd300, 0, 0, 1'b0);
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL illegal_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL illegal_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    run_entry(29'd4, 3'd0, 1'b0, 64'h0, 64'h0, 64'd0, 0, 0, 1'b0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h20 || got_q[1] !== 8'h00) begin
      errors++; $display("FAIL zero_value got n=%0d exp n=2 bytes 20 00", got_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp[$];
    // Reset while a request is outstanding in FETCH.
    @(negedge clk);
    in_entry.field_id = 29'd7; in_entry.field_type = 3'd0; in_entry.nested = 1'b0; in_entry.offset = 64'h8;
    cpp_base_addr = 64'h40; in_entry_valid = 1'b1; out_byte_ready = 1'b1; mem_gnt = 1'b0;
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    in_entry_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h48) begin
      errors++; $display("FAIL fetch_reached got req=%b addr=%h exp req=1 addr=48", mem_req, mem_addr);
    end
    #2 reset = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 64'd0 || ser_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_fetch got req=%b addr=%h rdy=%b exp 0 0 1", mem_req, mem_addr, ser_ready);
    end
    @(negedge clk); reset = 1'b1;
    // Reset in WAIT, then a stale rvalid after release.
    @(negedge clk);
    in_entry_valid = 1'b1;
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    in_entry_valid = 1'b0;
    mem_gnt = 1'b1; @(negedge clk); mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || ser_ready !== 1'b0) begin
      errors++; $display("FAIL wait_reached got req=%b rdy=%b exp 0 0", mem_req, ser_ready);
    end
    #2 reset = 1'b0; #1;
    checks++;
    if ({ser_ready, ser_done, mem_req, out_byte_valid} !== 4'b1000 || mem_addr !== 64'd0 || out_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_wait got rdy/done/req/vld=%b addr=%h byte=%h exp 1000 0 00",
               {ser_ready, ser_done, mem_req, out_byte_valid}, mem_addr, out_byte);
    end
    @(negedge clk); reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'd99;
    @(negedge clk); mem_rvalid = 1'b0;
    checks++;
    if (ser_ready !== 1'b1 || out_byte_valid !== 1'b0) begin
      errors++; $display("FAIL stale_rvalid got rdy=%b vld=%b exp rdy=1 vld=0", ser_ready, out_byte_valid);
    end
    exp = '{8'h38, 8'h01};
    run_entry(29'd7, 3'd0, 1'b0, 64'h40, 64'h8, 64'd1, 0, 0, 1'b0);
    checks++;
    if (got_q.size() != exp.size()) begin errors++; $display("FAIL post_reset_len got=%0d exp=%0d", got_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL post_reset_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (done_cnt != 1 || addr_seen !== 64'h48) begin
      errors++; $display("FAIL post_reset_done got done=%0d addr=%h exp 1 48", done_cnt, addr_seen);
    end
  endtask

  initial begin
    reset = 1'b0; in_entry = '0; in_entry_valid = 1'b0; cpp_base_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_byte_ready = 1'b0;
    test_reset();
    test_varint_basic();
    test_fixed32();
    test_nested_and_end();
    test_varint_stall();
    test_fixed64();
    test_illegal_and_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
